// File: rtl/operand_loader_if.sv
// operand_loader_if: key/switch inputs and latched operand outputs of the operand loader
// master: board side, drives key_n, sw_in, sw_mode and observes the latched operand set
// slave : loader side, samples the keys and switches and drives a, b, mode, cin, valid, state
interface operand_loader_if;
   logic [1:0] key_n;
   logic [3:0] sw_in;
   logic [1:0] sw_mode;
   logic [3:0] a;
   logic [3:0] b;
   logic [1:0] mode;
   logic       cin;
   logic       valid;
   logic [1:0] state;
   modport master (output key_n, sw_in, sw_mode, input a, b, mode, cin, valid, state);
   modport slave (input key_n, sw_in, sw_mode, output a, b, mode, cin, valid, state);
endinterface

// File: rtl/operand_loader.sv
// operand_loader: sequences pushbutton entry of operands A, B, operation select and carry-in
// clk, rst : clock and asynchronous active-high reset
// bus      : slave side of operand_loader_if; key_n[0]=enter, key_n[1]=clear (active-low),
//            sw_in/sw_mode switches in; registered a, b, mode, cin, valid, state out
// LOADER_DEBOUNCE_EN: when defined each key is debounced over DB_CYCLES cycles;
//            otherwise the press event comes straight from the synchronized key level
module operand_loader #(
   parameter int DB_CYCLES = 1000000,
   parameter int DB_W = 20
) (
   input logic clk,
   input logic rst,
   operand_loader_if.slave bus
);
   typedef enum logic [1:0] {LOAD_A = 2'b00, LOAD_B = 2'b01, LOAD_OP = 2'b10, RUN = 2'b11} state_t;
   state_t st;
   logic [1:0] s1, s2, lvl, lvl_q, press;
   logic [3:0] a, b;
   logic [1:0] mode;
   logic cin, valid;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1 <= 2'b11;
         s2 <= 2'b11;
      end else begin
         s1 <= bus.key_n;
         s2 <= s1;
      end
`ifdef LOADER_DEBOUNCE_EN
   for (genvar k = 0; k < 2; k++) begin : g_db
      logic [DB_W-1:0] cnt;
      logic d;
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            cnt <= '0;
            d <= 1'b1;
         end else if (s2[k] == d) cnt <= '0;
         else if (cnt == DB_W'(DB_CYCLES - 1)) begin
            cnt <= '0;
            d <= s2[k];
         end else cnt <= cnt + 1'b1;
      assign lvl[k] = d;
   end
`else
   logic unused_db;
   assign unused_db = ^{32'(DB_CYCLES), 32'(DB_W)};
   assign lvl = s2;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) lvl_q <= 2'b11;
      else lvl_q <= lvl;
   // one pulse per debounced falling edge; releases are ignored
   assign press = lvl_q & ~lvl;
   // clear is checked first so a simultaneous enter is dropped
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st <= LOAD_A;
         a <= '0;
         b <= '0;
         mode <= '0;
         cin <= 1'b0;
         valid <= 1'b0;
      end else if (press[1]) begin
         st <= LOAD_A;
         a <= '0;
         b <= '0;
         mode <= '0;
         cin <= 1'b0;
         valid <= 1'b0;
      end else if (press[0])
         case (st)
            LOAD_A: begin
               a <= bus.sw_in;
               st <= LOAD_B;
            end
            LOAD_B: begin
               b <= bus.sw_in;
               st <= LOAD_OP;
            end
            LOAD_OP: begin
               // the downstream mux has only three inputs, so 11 folds to ripple add
               mode <= (&bus.sw_mode) ? 2'b00 : bus.sw_mode;
               cin <= bus.sw_in[0];
               valid <= 1'b1;
               st <= RUN;
            end
            default: begin
               valid <= 1'b0;
               st <= LOAD_A;
            end
         endcase
   assign bus.a = a;
   assign bus.b = b;
   assign bus.mode = mode;
   assign bus.cin = cin;
   assign bus.valid = valid;
   assign bus.state = st;
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed scoreboard bench for operand_loader
module tb_operand_loader;
   logic clk, rst;
   int n_cmp, n_bad;
   operand_loader_if bus ();
   operand_loader #(.DB_CYCLES(4), .DB_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef LOADER_DEBOUNCE_EN
   localparam int LAT = 7;
`else
   localparam int LAT = 3;
`endif
   typedef struct {
      string tag;
      logic [3:0] a, b;
      logic [1:0] mode;
      logic cin, valid;
      logic [1:0] st;
   } want_t;
   want_t sb[$];
   always #5 clk = ~clk;
   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask
   task automatic push(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] mode, input logic cin, input logic valid, input logic [1:0] st);
      want_t w;
      w.tag = tag; w.a = a; w.b = b; w.mode = mode; w.cin = cin; w.valid = valid; w.st = st;
      sb.push_back(w);
   endtask
   task automatic check_pop();
      want_t w;
      w = sb.pop_front();
      cmp({w.tag, ".a"}, 32'(bus.a), 32'(w.a));
      cmp({w.tag, ".b"}, 32'(bus.b), 32'(w.b));
      cmp({w.tag, ".mode"}, 32'(bus.mode), 32'(w.mode));
      cmp({w.tag, ".cin"}, 32'(bus.cin), 32'(w.cin));
      cmp({w.tag, ".valid"}, 32'(bus.valid), 32'(w.valid));
      cmp({w.tag, ".state"}, 32'(bus.state), 32'(w.st));
   endtask
   task automatic press(input logic [1:0] keys, input int hold);
      bus.key_n = ~keys;
      repeat (hold) @(posedge clk);
      #1 bus.key_n = 2'b11;
      repeat (15) @(posedge clk);
      #1;
   endtask
   task automatic press_lat(input string tag);
      logic [1:0] old;
      int lat;
      old = bus.state;
      lat = 0;
      bus.key_n[0] = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (lat == 0 && bus.state !== old) lat = i;
      end
      bus.key_n[0] = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      cmp(tag, 32'(lat), 32'(LAT));
   endtask
   initial begin
      clk = 0;
      rst = 1;
      bus.key_n = 2'b11;
      bus.sw_in = 4'h0;
      bus.sw_mode = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      push("reset", 4'h0, 4'h0, 2'b00, 0, 0, 2'b00);
      check_pop();
      rst = 0;
      repeat (3) @(posedge clk);
      #1;
      bus.sw_in = 4'h5;
      push("load_a", 4'h5, 4'h0, 2'b00, 0, 0, 2'b01);
      press_lat("enter_latency");
      check_pop();
      bus.sw_in = 4'hA;
      push("load_b", 4'h5, 4'hA, 2'b00, 0, 0, 2'b10);
      press(2'b01, 10);
      bus.sw_in = 4'hF;
      bus.sw_mode = 2'b01;
      repeat (20) @(posedge clk);
      #1;
      check_pop();
      bus.sw_mode = 2'b10;
      bus.sw_in = 4'h1;
      push("load_op", 4'h5, 4'hA, 2'b10, 1, 1, 2'b11);
      press(2'b01, 10);
      check_pop();
      push("run_exit", 4'h5, 4'hA, 2'b10, 1, 0, 2'b00);
      press(2'b01, 10);
      check_pop();
`ifdef LOADER_DEBOUNCE_EN
      bus.sw_in = 4'hC;
      push("bounce", 4'h5, 4'hA, 2'b10, 1, 0, 2'b00);
      bus.key_n[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1 bus.key_n[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1 bus.key_n[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 bus.key_n[0] = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      check_pop();
`endif
      bus.sw_in = 4'h3;
      push("hold", 4'h3, 4'hA, 2'b10, 1, 0, 2'b01);
      press(2'b01, 50);
      check_pop();
      bus.sw_in = 4'h6;
      push("load_b2", 4'h3, 4'h6, 2'b10, 1, 0, 2'b10);
      press(2'b01, 10);
      check_pop();
      bus.sw_mode = 2'b01;
      bus.sw_in = 4'hF;
      push("clear_wins", 4'h0, 4'h0, 2'b00, 0, 0, 2'b00);
      press(2'b11, 10);
      check_pop();
      bus.sw_in = 4'h9;
      press(2'b01, 10);
      bus.sw_in = 4'h4;
      press(2'b01, 10);
      bus.sw_mode = 2'b11;
      bus.sw_in = 4'h7;
      push("illegal_mode", 4'h9, 4'h4, 2'b00, 1, 1, 2'b11);
      press(2'b01, 10);
      check_pop();
      push("async_reset", 4'h0, 4'h0, 2'b00, 0, 0, 2'b00);
      @(posedge clk);
      #2 rst = 1;
      #1;
      check_pop();
      @(posedge clk);
      #1 rst = 0;
      repeat (3) @(posedge clk);
      #1;
      bus.sw_in = 4'h8;
      push("after_reset", 4'h8, 4'h0, 2'b00, 0, 0, 2'b01);
      press(2'b01, 10);
      check_pop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
